// File: rtl/sd_digit_serializer.sv
// Parallel-word to MSB-first radix-2 signed-digit serializer with frame markers.
// Define SD_SERIALIZER_BOOTH_EN to Booth-recode the word instead of plain mapping.
module sd_digit_serializer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [0:WIDTH-1] ld_data,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [1:0]       dig_out,
  output logic             dig_sof,
  output logic             dig_eof,
  output logic             busy,
  output logic [CNT_W-1:0] frames
);

  // state | meaning
  // IDLE  | no frame in progress, ready for a word
  // SEND  | presenting digit idx_q of the captured word

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [0:WIDTH-1] sr_q;
  logic [IDX_W-1:0] idx_q;
  logic             last, accept, xfer;
  logic [1:0]       digit;

  assign last   = (idx_q == IDX_W'(WIDTH - 1));
  assign accept = ld_valid & ld_ready;
  assign xfer   = (state_q == SEND) & dig_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ld_valid) state_d = SEND;
      SEND:    if (dig_ready && last && !ld_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // sr_q[0] is always the current digit's bit; shifting pulls in x_WIDTH = 0.
`ifdef SD_SERIALIZER_BOOTH_EN
  always_comb begin
    digit = {~sr_q[0] & sr_q[1], sr_q[0] & ~sr_q[1]};
  end
`else
  always_comb begin
    digit = {sr_q[0], 1'b0};
  end
`endif

  always_comb begin
    ld_ready  = 1'b0;
    dig_valid = 1'b0;
    busy      = 1'b0;
    dig_sof   = 1'b0;
    dig_eof   = 1'b0;
    dig_out   = 2'b00;
    case (state_q)
      IDLE: ld_ready = 1'b1;
      SEND: begin
        ld_ready  = last & dig_ready;
        dig_valid = 1'b1;
        busy      = 1'b1;
        dig_sof   = (idx_q == '0);
        dig_eof   = last;
        dig_out   = digit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q   <= '0;
      idx_q  <= '0;
      frames <= '0;
    end else begin
      if (accept) begin
        sr_q  <= ld_data;
        idx_q <= '0;
      end else if (xfer) begin
        sr_q  <= {sr_q[1:WIDTH-1], 1'b0};
        idx_q <= last ? '0 : idx_q + IDX_W'(1);
      end
      if (xfer && last) frames <= frames + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sd_digit_serializer.sv
// Scoreboard bench for sd_digit_serializer: expected digits queued on accept, popped on transfer.
module tb_sd_digit_serializer;
  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             ld_valid = 1'b0;
  logic             ld_ready;
  logic [0:WIDTH-1] ld_data = '0;
  logic             dig_valid;
  logic             dig_ready = 1'b1;
  logic [1:0]       dig_out;
  logic             dig_sof, dig_eof, busy;
  logic [CNT_W-1:0] frames;

  sd_digit_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .dig_valid(dig_valid), .dig_ready(dig_ready),
    .dig_out(dig_out), .dig_sof(dig_sof), .dig_eof(dig_eof), .busy(busy),
    .frames(frames)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] d;
    logic       sof;
    logic       eof;
  } exp_t;

  exp_t             q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  int               rem = 0;
  int               xfer_cnt = 0;
  logic [CNT_W-1:0] exp_frames = '0;
  logic             acc_flag = 1'b0;
  logic             rdy_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_dig(input logic [0:WIDTH-1] w, input int j);
    logic xj, xn;
    xj = w[j];
    xn = (j == WIDTH - 1) ? 1'b0 : w[j+1];
`ifdef SD_SERIALIZER_BOOTH_EN
    if (!xj && xn)      return 2'b10;
    else if (xj && !xn) return 2'b01;
    else                return 2'b00;
`else
    return xj ? 2'b10 : 2'b00;
`endif
  endfunction

  // Reference model of the handshake, evaluated mid-cycle.
  always @(negedge clk) begin
    logic exp_rdy;
    exp_t e;
    if (reset) begin
      exp_rdy = (rem == 0) || (rem == 1 && dig_ready);
      chk("ld_ready", 32'(ld_ready), 32'(exp_rdy));
      chk("dig_valid", 32'(dig_valid), 32'(rem > 0));
      chk("busy", 32'(busy), 32'(rem > 0));
      chk("frames", 32'(frames), 32'(exp_frames));
      if (rem == 0) begin
        chk("idle_out", 32'({dig_out, dig_sof, dig_eof}), 32'd0);
      end else if (q.size() == 0) begin
        chk("underflow", 32'd1, 32'd0);
      end else begin
        e = q[0];
        chk("digit", 32'(dig_out), 32'(e.d));
        chk("sof", 32'(dig_sof), 32'(e.sof));
        chk("eof", 32'(dig_eof), 32'(e.eof));
        if (dig_ready) begin
          void'(q.pop_front());
          rem--;
          xfer_cnt++;
          if (e.eof) exp_frames = exp_frames + 1'b1;
        end
      end
      acc_flag = ld_valid && exp_rdy;
      if (acc_flag) begin
        for (int j = 0; j < WIDTH; j++) begin
          e.d   = exp_dig(ld_data, j);
          e.sof = (j == 0);
          e.eof = (j == WIDTH - 1);
          q.push_back(e);
        end
        rem += WIDTH;
      end
    end else begin
      acc_flag = 1'b0;
    end
  end

  // dig_ready driver: always ready, or the repeating 1,0,0,1 stall pattern.
  initial begin
    int ph = 0;
    logic [3:0] pat = 4'b1001;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) begin
        dig_ready = pat[3-ph];
        ph = (ph + 1) % 4;
      end else begin
        dig_ready = 1'b1;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the word was accepted.
  task automatic send(input logic [WIDTH-1:0] w, input bit hold);
    int n = 0;
    ld_valid = 1'b1;
    ld_data  = w;
    do begin
      @(posedge clk);
      n++;
    end while (!acc_flag && n < 200);
    if (!acc_flag) chk("accept_timeout", 32'd0, 32'd1);
    #1;
    if (!hold) ld_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while ((rem != 0 || q.size() != 0) && n < 500);
    if (rem != 0) chk("idle_timeout", 32'd0, 32'd1);
    #1;
  endtask

  initial begin
    int n, start;
    #2;
    chk("rst_valid", 32'(dig_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frames", 32'(frames), 32'd0);
    chk("rst_out", 32'({dig_out, dig_sof, dig_eof}), 32'd0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", 32'(ld_ready), 32'd1);

    send(16'hA000, 1'b0);
    wait_idle();
    chk("frames_a000", 32'(frames), 32'd1);

    rdy_mode = 1'b1;
    send(16'hFFFF, 1'b0);
    wait_idle();
    rdy_mode = 1'b0;
    chk("frames_bp", 32'(frames), 32'd2);

    send(16'h0001, 1'b1);
    send(16'h8000, 1'b0);
    wait_idle();
    send(16'h7FFF, 1'b0);
    wait_idle();
    send(16'h8000, 1'b0);
    wait_idle();
    chk("frames_b2b", 32'(frames), 32'd6);

    start = xfer_cnt;
    send(16'hFFFF, 1'b0);
    n = 0;
    while (xfer_cnt - start < 7 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1 reset = 1'b0;
    #1;
    chk("abort_valid", 32'(dig_valid), 32'd0);
    chk("abort_frames", 32'(frames), 32'd0);
    q.delete();
    rem = 0;
    exp_frames = '0;
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    send(16'h1234, 1'b0);
    wait_idle();
    chk("frames_post_rst", 32'(frames), 32'd1);

    for (int i = 0; i < 255; i++) send(16'($urandom_range(0, 65535)), i < 254);
    wait_idle();
    chk("frames_wrap", 32'(frames), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sd_digit_serializer.md
Name: sd_digit_serializer

Overview:
- Transmit-side companion to the on-the-fly SD-to-binary converter.
- Accepts a parallel WIDTH-bit word and emits it MSB-first as a serial stream of radix-2 signed digits, one digit per cycle, using the same 2-bit digit code.
- Sits between the word-level datapath and any online-arithmetic consumer.
- Frame markers let the consumer clear its accumulators at the start of each word.

Parameters:
- WIDTH, 16: word width and digits per frame; index 0 is the MSB.
- CNT_W, 8: width of the frame counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ld_valid  in  1  ld_data is valid this cycle.
- ld_ready  out  1  block can accept a word this cycle.
- ld_data  in  [0:WIDTH-1]  word to serialize; bit 0 is the MSB.
- dig_valid  out  1  dig_out holds a valid digit.
- dig_ready  in  1  consumer accepts the digit (tie to 1 for consumers without backpressure).
- dig_out  out  2  digit code: 10 = +1, 01 = -1, 00 = 0; 11 is never driven.
- dig_sof  out  1  high with digit 0 of a frame; drives the consumer's clear.
- dig_eof  out  1  high with digit WIDTH-1.
- busy  out  1  a frame is in progress.
- frames  out  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - dig_valid=0, dig_out=00, dig_sof=0, dig_eof=0, busy=0, frames=0, digit index=0, shift register=0.
  - ld_ready=1 as soon as reset is released.
- State machine: IDLE and SEND.
- IDLE:
  - ld_ready=1.
  - When ld_valid=1, the word is captured, index is set to 0 and the next state is SEND.
  - The first digit appears registered on the cycle after the accept.
- SEND:
  - dig_valid=1 and busy=1.
  - dig_out, dig_sof and dig_eof are registered and held stable while dig_ready=0. No digit is dropped or duplicated.
  - A transfer occurs when dig_valid and dig_ready are both 1; the index then increments.
  - On transfer of index WIDTH-1: frames increments, and the next state is IDLE unless a new word is accepted in the same cycle.
- Back-to-back frames:
  - ld_ready = IDLE or (SEND and index==WIDTH-1 and dig_ready).
  - A word accepted on the last-digit transfer starts its digit 0 (with dig_sof) on the very next cycle, giving zero-bubble streaming.
- Digit mapping, default build (plain): digit j = x_j. Bit 1 gives 10, bit 0 gives 00. No -1 digits are produced.
- dig_sof=1 only while index==0; dig_eof=1 only while index==WIDTH-1. Both are 0 whenever dig_valid=0.
- ld_valid while busy and ld_ready=0 is ignored; the word is not captured.
- Reset mid-frame aborts the frame immediately. Remaining digits are never emitted and frames does not increment.
- frames wraps from 2^CNT_W-1 to 0 without a flag.

Optional Feature:
- Macro: SD_SERIALIZER_BOOTH_EN.
- Defined: Booth recoding of a two's-complement fraction.
  - d_j = x_{j+1} - x_j, with x_WIDTH = 0.
  - Bit pair (x_j, x_{j+1}) maps as: (0,0) or (1,1) give 00; (0,1) gives 10; (1,0) gives 01.
  - The digit sum with weights 2^-j equals -x_0 + sum over k≥1 of x_k·2^-k.
  - Handshake, timing and markers are identical to the default build.
- Undefined: plain mapping only; there is no recoding logic.

Test Plan:
- Reset, then ld_data=0xA000 with dig_ready=1 → accept on cycle 0; cycles 1..16 give digits 10,00,10,00, then twelve 00. dig_sof on cycle 1, dig_eof on cycle 16, frames=1, ld_ready=1 on cycle 17.
- Booth build, ld_data=0x7FFF → digit0=10, digits1..14=00, digit15=01. Booth build, 0x8000 → digit0=01, rest 00.
- Backpressure: 0xFFFF with dig_ready toggling 1,0,0,1 → dig_out and markers held while stalled; exactly 16 transfers; frames=1.
- Back-to-back: ld_valid held with words 0x0001 then 0x8000 → second frame's dig_sof appears on the cycle after the first frame's dig_eof transfer, with no bubble.
- Reset pulse at digit 7 of 0xFFFF → dig_valid=0 immediately; frames stays 0; next word starts at digit 0 with dig_sof.
- 256 frames with CNT_W=8 → frames wraps to 0.
